// File: rtl/fpgamath_pkg.sv
// Shared definitions for the fpgamath datapath blocks.
package fpgamath_pkg;

  // Error source bit positions, for when more sticky error sources are added.
  localparam int ERR_DROP = 0;

  // Widest requester vector rr_pick can handle.
  localparam int RR_MAX = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // One-hot round-robin pick: first set bit of req scanning upward from ptr,
  // wrapping at n-1 back to 0. Bits at or above n are ignored.
  function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] req,
                                                 input logic [2:0] ptr,
                                                 input int n);
    logic [RR_MAX-1:0] pick;
    logic              found;
    int                idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < RR_MAX; k++) begin
      if (k < n) begin
        idx = int'(ptr) + k;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx[2:0]]) begin
          pick[idx[2:0]] = 1'b1;
          found          = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/multiply.sv
// Pipelined signed multiplier: z is the low WIDTH bits of the two's
// complement product x*y (wraps on overflow), LATENCY edges after x/y.
module multiply #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z
);

  // Low half of a product is identical for signed and unsigned operands.
  logic [WIDTH-1:0] prod;
  logic [WIDTH-1:0] pipe [LATENCY];

  assign prod = x * y;

  // Product pipeline, cleared on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= prod;
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign z = pipe[LATENCY-1];

endmodule

// File: rtl/multiply_sched.sv
// Round-robin scheduler sharing one pipelined multiply among N_REQ requesters.
// Requester id and metadata ride a valid/id/tag shift register alongside the
// multiplier so each product returns to its owner via a one-hot out_nd.
module multiply_sched
  import fpgamath_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int N_REQ        = 4,
  parameter int MWIDTH       = 1,
  parameter int MULT_LATENCY = 3,
  parameter int IDW          = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        in_req,
  input  logic [N_REQ*WIDTH-1:0]  in_x,
  input  logic [N_REQ*WIDTH-1:0]  in_y,
  input  logic [N_REQ*MWIDTH-1:0] in_m,
  input  logic                    in_en,
  output logic [N_REQ-1:0]        out_ack,
  output logic [WIDTH-1:0]        out_z,
  output logic [N_REQ-1:0]        out_nd,
  output logic [IDW-1:0]          out_id,
  output logic [MWIDTH-1:0]       out_m,
  output logic                    busy,
  output logic                    error
);

  // Input register stage plus MULT_LATENCY multiplier stages.
  localparam int DEPTH = MULT_LATENCY + 1;
  localparam int LAST  = DEPTH - 1;

  logic [IDW-1:0]    ptr_q;
  logic [RR_MAX-1:0] req_ext;
  logic [RR_MAX-1:0] pick;
  logic              grant;
  logic [IDW-1:0]    win;
  logic [WIDTH-1:0]  x_r, y_r;
  logic [N_REQ-1:0]  pend_q;
  logic              error_q;
  logic [DEPTH-1:0]  vld_q;
  logic [IDW-1:0]    id_q [DEPTH];
  logic [MWIDTH-1:0] m_q  [DEPTH];

  // Round-robin arbitration; no grant while in reset or issue is disabled.
  always_comb begin
    req_ext            = '0;
    req_ext[N_REQ-1:0] = in_req;
    pick               = rr_pick(req_ext, 3'(ptr_q), N_REQ);
    grant              = in_en && !rst && (|pick);
    out_ack            = grant ? pick[N_REQ-1:0] : '0;
  end

  // Binary id of the granted requester.
  always_comb begin
    win = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (out_ack[i]) win = IDW'(i);
    end
  end

  // Pointer, operand capture and sticky dropped-request detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      x_r     <= '0;
      y_r     <= '0;
      pend_q  <= '0;
      error_q <= 1'b0;
    end else begin
      if (grant) begin
        ptr_q <= (win == IDW'(N_REQ - 1)) ? '0 : win + 1'b1;
        x_r   <= in_x[win*WIDTH +: WIDTH];
        y_r   <= in_y[win*WIDTH +: WIDTH];
      end
      pend_q  <= in_req & ~out_ack;
      error_q <= error_q | (|(pend_q & ~in_req));
    end
  end

  // Valid/id/tag shift register tracking products through the multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i] <= '0;
        m_q[i]  <= '0;
      end
    end else begin
      vld_q   <= {vld_q[DEPTH-2:0], grant};
      id_q[0] <= grant ? win : '0;
      m_q[0]  <= grant ? in_m[win*MWIDTH +: MWIDTH] : '0;
      for (int i = 1; i < DEPTH; i++) begin
        id_q[i] <= id_q[i-1];
        m_q[i]  <= m_q[i-1];
      end
    end
  end

  multiply #(
    .WIDTH   (WIDTH),
    .LATENCY (MULT_LATENCY)
  ) u_multiply (
    .clk   (clk),
    .rst_n (~rst),
    .x     (x_r),
    .y     (y_r),
    .z     (out_z)
  );

  // Result strobe decoded from the last shift-register stage.
  always_comb begin
    out_nd = '0;
    if (vld_q[LAST]) out_nd[id_q[LAST]] = 1'b1;
  end

  assign out_id = id_q[LAST];
  assign out_m  = m_q[LAST];
  assign busy   = |vld_q;
  assign error  = error_q;

endmodule

// File: tb/tb_multiply_sched.sv
// Directed bench for multiply_sched with N_REQ=4, MULT_LATENCY=3, WIDTH=16.
module tb_multiply_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_req;
  logic [63:0] in_x, in_y;
  logic [3:0]  in_m;
  logic        in_en;
  logic [3:0]  out_ack;
  logic [15:0] out_z;
  logic [3:0]  out_nd;
  logic [1:0]  out_id;
  logic [0:0]  out_m;
  logic        busy;
  logic        error;

  int n_cmp  = 0;
  int n_fail = 0;

  multiply_sched #(
    .WIDTH(16), .N_REQ(4), .MWIDTH(1), .MULT_LATENCY(3)
  ) dut (
    .clk(clk), .rst(rst), .in_req(in_req), .in_x(in_x), .in_y(in_y),
    .in_m(in_m), .in_en(in_en), .out_ack(out_ack), .out_z(out_z),
    .out_nd(out_nd), .out_id(out_id), .out_m(out_m), .busy(busy),
    .error(error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Operand set for the multi-requester tests, products hand-computed:
  // r0 2*3=6, r1 -3*4=-12, r2 100*300=30000, r3 -7*-9=63.
  logic [15:0] zexp [4] = '{16'h0006, 16'hFFF4, 16'h7530, 16'h003F};
  logic [0:0]  mexp [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [3:0]  req_v;

  initial begin
    rst    = 1'b1;
    in_req = 4'hF;
    in_en  = 1'b1;
    in_x   = '0;
    in_y   = '0;
    in_m   = '0;

    // Reset state; grants suppressed while rst is high.
    tick(); tick();
    #1;
    chk("rst_ack", 32'(out_ack), 32'h0);
    chk("rst_nd", 32'(out_nd), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_error", 32'(error), 32'h0);
    chk("rst_id", 32'(out_id), 32'h0);
    chk("rst_m", 32'(out_m), 32'h0);
    tick();
    in_req = 4'h0;

    // Single request: req 2, x=3, y=-5.
    tick();
    rst    = 1'b0;
    in_x   = {16'h0000, 16'h0003, 16'h0000, 16'h0000};
    in_y   = {16'h0000, 16'hFFFB, 16'h0000, 16'h0000};
    in_m   = 4'b0100;
    in_req = 4'b0100;
    #1;
    chk("single_ack", 32'(out_ack), 32'h4);
    tick();
    in_req = 4'b0000;
    #1;
    chk("single_busy1", 32'(busy), 32'h1);
    chk("single_nd1", 32'(out_nd), 32'h0);
    tick(); tick(); #1;
    chk("single_busy3", 32'(busy), 32'h1);
    chk("single_nd3", 32'(out_nd), 32'h0);
    tick(); #1;
    chk("single_nd", 32'(out_nd), 32'h4);
    chk("single_id", 32'(out_id), 32'h2);
    chk("single_z", 32'(out_z), 32'h0000FFF1);
    chk("single_m", 32'(out_m), 32'h1);
    chk("single_busy4", 32'(busy), 32'h1);
    tick(); #1;
    chk("single_nd_off", 32'(out_nd), 32'h0);
    chk("single_busy_off", 32'(busy), 32'h0);

    // Reset back to ptr=0, then all four requesting.
    tick();
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    in_x = {16'hFFF9, 16'h0064, 16'hFFFD, 16'h0002};
    in_y = {16'hFFF7, 16'h012C, 16'h0004, 16'h0003};
    in_m = 4'b0110;
    req_v = 4'hF;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) tick();
      in_req = req_v;
      #1;
      chk($sformatf("all_ack_%0d", k), 32'(out_ack), (k < 8) ? 32'(1 << (k % 4)) : 32'h0);
      if (k >= 4) begin
        chk($sformatf("all_nd_%0d", k), 32'(out_nd), 32'(1 << (k % 4)));
        chk($sformatf("all_id_%0d", k), 32'(out_id), 32'(k % 4));
        chk($sformatf("all_z_%0d", k), 32'(out_z), 32'(zexp[k % 4]));
        chk($sformatf("all_m_%0d", k), 32'(out_m), 32'(mexp[k % 4]));
      end
      if (k >= 4 && k < 8) req_v = req_v & ~4'(1 << (k % 4));
    end
    chk("all_error", 32'(error), 32'h0);

    // Requesters 1 and 3 only: alternating grants from ptr=0.
    tick(); in_req = 4'b1010; #1; chk("alt_ack0", 32'(out_ack), 32'h2);
    tick(); in_req = 4'b1010; #1; chk("alt_ack1", 32'(out_ack), 32'h8);
    tick(); in_req = 4'b1010; #1; chk("alt_ack2", 32'(out_ack), 32'h2);
    tick(); in_req = 4'b1000; #1; chk("alt_ack3", 32'(out_ack), 32'h8);
    tick(); in_req = 4'b0000; #1; chk("alt_nd0", 32'(out_nd), 32'h2);
    tick(); #1; chk("alt_nd1", 32'(out_nd), 32'h8);
    tick(); #1; chk("alt_nd2", 32'(out_nd), 32'h2);
    tick(); #1; chk("alt_nd3", 32'(out_nd), 32'h8);
    chk("alt_error", 32'(error), 32'h0);

    // in_en low for 5 cycles with requests pending.
    tick(); in_req = 4'b0101; #1; chk("en_ack_d0", 32'(out_ack), 32'h1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      in_en = 1'b0;
      #1;
      chk($sformatf("en_ack_off_%0d", k), 32'(out_ack), 32'h0);
      if (k == 4) chk("en_inflight_nd", 32'(out_nd), 32'h1);
    end
    tick(); in_en = 1'b1; #1; chk("en_ack_d6", 32'(out_ack), 32'h4);
    tick(); in_req = 4'b0001; #1; chk("en_ack_d7", 32'(out_ack), 32'h1);
    tick(); in_req = 4'b0000; #1; chk("en_nd_d8", 32'(out_nd), 32'h0);
    tick(); #1; chk("en_nd_d9", 32'(out_nd), 32'h0);
    tick(); #1; chk("en_nd_d10", 32'(out_nd), 32'h4);
    tick(); #1; chk("en_nd_d11", 32'(out_nd), 32'h1);
    chk("en_error", 32'(error), 32'h0);

    // Requester 0 drops while requester 3 is granted.
    tick(); in_req = 4'b1001; #1;
    chk("err_ack", 32'(out_ack), 32'h8);
    chk("err_pre", 32'(error), 32'h0);
    tick(); in_req = 4'b0000;
    tick(); #1; chk("err_set", 32'(error), 32'h1);
    tick(); tick(); #1;
    chk("err_nd", 32'(out_nd), 32'h8);
    chk("err_sticky", 32'(error), 32'h1);
    tick();

    // Reset two cycles after three issues discards in-flight products.
    tick(); in_req = 4'b0111; #1; chk("mid_ack0", 32'(out_ack), 32'h1);
    tick(); #1; chk("mid_ack1", 32'(out_ack), 32'h2);
    tick(); #1; chk("mid_ack2", 32'(out_ack), 32'h4);
    tick(); in_req = 4'b0000; rst = 1'b1; #1;
    chk("mid_error_held", 32'(error), 32'h1);
    tick(); in_req = 4'b0110; #1;
    chk("mid_rst_ack", 32'(out_ack), 32'h0);
    chk("mid_rst_nd", 32'(out_nd), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_error", 32'(error), 32'h0);
    chk("mid_rst_id", 32'(out_id), 32'h0);
    chk("mid_rst_m", 32'(out_m), 32'h0);
    tick(); rst = 1'b0; #1;
    chk("post_ack0", 32'(out_ack), 32'h2);
    chk("post_nd5", 32'(out_nd), 32'h0);
    tick(); in_req = 4'b0100; #1;
    chk("post_ack1", 32'(out_ack), 32'h4);
    chk("post_nd6", 32'(out_nd), 32'h0);
    tick(); in_req = 4'b0000; #1; chk("post_nd7", 32'(out_nd), 32'h0);
    tick(); #1; chk("post_nd8", 32'(out_nd), 32'h0);
    tick(); #1;
    chk("post_nd9", 32'(out_nd), 32'h2);
    chk("post_z9", 32'(out_z), 32'h0000FFF4);
    chk("post_error", 32'(error), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
